ext_bus_master: RTL

- Initiator side of the external peripheral bus (op/rw/addr/data_w/data_r) that the memory-mapped GPIO and other ext_* responders sit on.
- Accepts one request at a time from the core's load/store path over a valid/ready handshake and drives the bus.
- Captures read data and returns a response through a one-entry response buffer with backpressure.
- Rejects misaligned or out-of-window addresses without touching the bus.

---
 rtl/ext_bus_pkg.sv | 8 +
 rtl/ext_bus_master_if.sv | 30 +++
 rtl/ext_bus_addr_chk.sv | 14 +
 rtl/ext_bus_master.sv | 77 +++++++
 4 files changed

// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg: shared state encoding, bus direction codes and default peripheral window
package ext_bus_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  localparam logic [31:0] WIN_BASE_DEF = 32'hf000_0000;
  localparam logic [31:0] WIN_MASK_DEF = 32'hffff_ff00;
  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;
endpackage

// File: rtl/ext_bus_master_if.sv
// ext_bus_master_if: request/response handshake plus external bus (op/rw/addr/data_w/data_r)
//   master: core-facing req_*/resp_* and bus-driving side of ext_bus_master
//   slave : the opposite view (requester + bus responder)
interface ext_bus_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  op;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_w;
  logic [DATA_WIDTH-1:0] data_r;
  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, resp_ready, data_r,
    output req_ready, resp_valid, resp_rdata, resp_err, op, rw, addr, data_w
  );
  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, resp_ready, data_r,
    input  req_ready, resp_valid, resp_rdata, resp_err, op, rw, addr, data_w
  );
endinterface

// File: rtl/ext_bus_addr_chk.sv
// ext_bus_addr_chk: flags misaligned or out-of-window request addresses
//   addr: request byte address; err: 1 when the request must be rejected
module ext_bus_addr_chk
  import ext_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] WIN_BASE   = WIN_BASE_DEF,
  parameter logic [ADDR_WIDTH-1:0] WIN_MASK   = WIN_MASK_DEF
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  err
);
  assign err = (|addr[1:0]) || ((addr & WIN_MASK) != WIN_BASE);
endmodule

// File: rtl/ext_bus_master.sv
// ext_bus_master: single-outstanding initiator for the external peripheral bus
//   sys_clk/sys_rst_n: clock and asynchronous active-low reset
//   bus (master modport): req_* request handshake, resp_* one-entry response, op/rw/addr/data_w/data_r bus
module ext_bus_master
  import ext_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] WIN_BASE   = WIN_BASE_DEF,
  parameter logic [ADDR_WIDTH-1:0] WIN_MASK   = WIN_MASK_DEF,
  parameter int                    RD_WAIT    = 0
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  ext_bus_master_if.master  bus
);
  localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);
  state_t                state, state_d;
  logic                  err, sample, op_q, rw_q, err_q;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  ext_bus_addr_chk #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WIN_BASE  (WIN_BASE),
    .WIN_MASK  (WIN_MASK)
  ) u_chk (
    .addr(bus.req_addr),
    .err (err)
  );
  always_comb begin
    state_d        = state;
    bus.req_ready  = state == IDLE;
    bus.resp_valid = state == RESP;
    case (state)
      IDLE:    state_d = bus.req_valid ? (err ? RESP : ISSUE) : IDLE;
      ISSUE:   state_d = (rw_q == BUS_WR || RD_WAIT_C == 4'd0) ? RESP : WAIT;
      WAIT:    state_d = cnt == 4'd1 ? RESP : WAIT;
      default: state_d = bus.resp_ready ? IDLE : RESP;
    endcase
  end
  // data_r is captured on the last posedge of the op window
  assign sample = (state == ISSUE && rw_q == BUS_RD && RD_WAIT_C == 4'd0) ||
                  (state == WAIT && cnt == 4'd1);
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      op_q    <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_d;
      // op is registered so it is glitch-free and still clears asynchronously on reset
      op_q  <= state_d == ISSUE || state_d == WAIT;
      if (state == IDLE && bus.req_valid) begin
        rw_q    <= bus.req_rw;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_rw == BUS_WR ? bus.req_wdata : '0;
        err_q   <= err;
        rdata_q <= '0;
      end
      if (sample) rdata_q <= bus.data_r;
      cnt <= (state == ISSUE && rw_q == BUS_RD) ? RD_WAIT_C :
             state == WAIT ? cnt - 4'd1 : cnt;
    end
  end
  assign bus.op         = op_q;
  assign bus.rw         = rw_q;
  assign bus.addr       = addr_q;
  assign bus.data_w     = wdata_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule
